// File: rtl/csr_gpio_if.sv
// csr_gpio_if: CSR access bundle between the control unit's csrrw decode
// and the GPIO peripheral. The master drives the write strobe, the address
// and the write data; the slave returns the old CSR value.
interface csr_gpio_if #(
    parameter int WIDTH = 32
);
    logic             gpio_we;
    logic [11:0]      csr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;

    modport master (output gpio_we, csr, wdata, input rdata);
    modport slave  (input gpio_we, csr, wdata, output rdata);
endinterface

// File: rtl/csr_gpio.sv
// csr_gpio: CSR-mapped GPIO. Output port register at 0xF02, debounced input
// at 0xF00, sticky change flag at 0xF01 (write-to-clear).
// Build option: define CSR_GPIO_DEBOUNCE_EN to build the whole-vector
// debouncer; without it the synchronized input feeds 'stable' directly.
module csr_gpio #(
    parameter int WIDTH     = 32,
    parameter int IN_WIDTH  = 18,
    parameter int DB_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    csr_gpio_if.slave           bus,
    input  logic [IN_WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0]    gpio_out,
    output logic                in_changed
);
    localparam logic [11:0] A_IN   = 12'hF00;
    localparam logic [11:0] A_STAT = 12'hF01;
    localparam logic [11:0] A_OUT  = 12'hF02;

    logic [IN_WIDTH-1:0] s1, s2;
    logic [IN_WIDTH-1:0] stable, stable_nxt;
    logic                stable_upd;
    logic                out_we, stat_we;

    assign out_we  = bus.gpio_we && (bus.csr == A_OUT);
    assign stat_we = bus.gpio_we && (bus.csr == A_STAT);

    // two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
        end
    end

`ifdef CSR_GPIO_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

    // COMMIT is a decode of the counter, not a separate register: the
    // candidate is adopted on the edge after the count saturates.
    typedef enum logic {TRACK, COMMIT} db_state_e;

    db_state_e           db_state;
    logic [IN_WIDTH-1:0] cand, cand_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;

    // debouncer state register; reset drops any pending candidate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand <= '0;
            cnt  <= '0;
        end else begin
            cand <= cand_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // whole-vector debounce: any bounce restarts the count, count saturates
    always_comb begin
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        db_state   = TRACK;
        if (s2 != cand) begin
            cand_nxt = s2;
            cnt_nxt  = '0;
        end else if (cnt < CNT_MAX) begin
            cnt_nxt = cnt + 1'b1;
        end
        if ((cnt == CNT_MAX) && (cand != stable)) begin
            db_state   = COMMIT;
            stable_nxt = cand;
        end
    end

    assign stable_upd = (db_state == COMMIT);
`else
    assign stable_nxt = s2;
    assign stable_upd = (s2 != stable);
`endif

    // debounced value and sticky change flag; a set beats a same-edge clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable     <= '0;
            in_changed <= 1'b0;
        end else begin
            stable <= stable_nxt;
            if (stable_upd)
                in_changed <= 1'b1;
            else if (stat_we)
                in_changed <= 1'b0;
        end
    end

    // output port register
    always_ff @(posedge clk) begin
        if (!rst_n)
            gpio_out <= '0;
        else if (out_we)
            gpio_out <= bus.wdata;
    end

    // read mux from registered state only, so a write cycle returns the old value
    always_comb begin
        bus.rdata = '0;
        case (bus.csr)
            A_IN:    bus.rdata = WIDTH'(stable);
            A_STAT:  bus.rdata = WIDTH'(in_changed);
            A_OUT:   bus.rdata = gpio_out;
            default: bus.rdata = '0;
        endcase
    end
endmodule
